// File: rtl/axi4_lite_read.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_read
//  Description : AXI4-Lite read-channel slave in front of a register file
//                with a one-cycle read latency. Each AR handshake runs
//                IDLE -> FETCH -> CAPTURE -> RESP. There is one transaction
//                in flight at most, so AR handshakes are at least 4 cycles
//                apart.
//                Optional feature macro: AXI4_LITE_READ_ADDR_CHECK_EN.
//                When it is defined, an address >= DEPTH gets SLVERR with
//                zero data and no register-file strobe. When it is not
//                defined, the address is truncated to the index width and
//                the response is OKAY.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_read #(
  parameter int DEPTH     = 4,
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_clk_ni,
  // AR channel
  input  logic [ADDR_SIZE-1:0]       read_address_i,
  input  logic                       read_address_valid_i,
  output logic                       read_address_ready_o,
  // R channel
  output logic [DATA_SIZE-1:0]       read_data_o,
  output logic [1:0]                 read_response_o,
  output logic                       read_data_valid_o,
  input  logic                       read_data_ready_i,
  // register-file side
  output logic [$clog2(DEPTH)-1:0]   register_address_o,
  output logic                       register_read_enable_o,
  input  logic [DATA_SIZE-1:0]       register_data_i
);

  localparam int         c_idx_w     = $clog2(DEPTH);
  localparam logic [1:0] c_resp_okay = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [DATA_SIZE-1:0]   r_data;
  logic [1:0]             r_resp;
  logic                   r_data_valid;
  logic [c_idx_w-1:0]     r_reg_addr;
  logic                   r_reg_rd_en;
  logic                   r_addr_err;

  logic                   w_ar_ready;
  logic                   w_ar_hs;
  logic                   w_addr_err;

`ifdef AXI4_LITE_READ_ADDR_CHECK_EN
  // The address is widened by one bit so that DEPTH fits even when
  // ADDR_SIZE equals the index width.
  localparam logic [ADDR_SIZE:0] c_depth_ext = (ADDR_SIZE+1)'(DEPTH);

  // An address at or beyond the register count is an error.
  assign w_addr_err = ({1'b0, read_address_i} >= c_depth_ext);
`else
  // The address is truncated, so no address can be out of range. The
  // upper address bits drop out here on purpose.
  logic w_unused_addr;
  assign w_unused_addr = ^read_address_i;
  assign w_addr_err    = 1'b0;
`endif

  // AR ready is decoded from the state. It is held low while reset is
  // applied, so the first accept comes after reset is released.
  assign w_ar_ready = (r_state == S_IDLE) && rst_clk_ni;
  assign w_ar_hs    = w_ar_ready && read_address_valid_i;

  // Single-process FSM. All outputs are registered and change with the state.
  always_ff @(posedge clk_i) begin
    if (!rst_clk_ni) begin
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_resp       <= 2'b00;
      r_data_valid <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_rd_en  <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      // The strobe is a single-cycle pulse. It is set only on leaving IDLE.
      r_reg_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_reg_addr  <= read_address_i[c_idx_w-1:0];
            r_addr_err  <= w_addr_err;
            r_reg_rd_en <= !w_addr_err;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          // The register file presents its data during the next cycle.
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_addr_err) begin
            r_data <= '0;
            r_resp <= c_resp_slverr;
          end else begin
            r_data <= register_data_i;
            r_resp <= c_resp_okay;
          end
          r_data_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          // Data and response hold until the master accepts the beat.
          if (read_data_ready_i) begin
            r_data_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign read_address_ready_o   = w_ar_ready;
  assign read_data_o            = r_data;
  assign read_response_o        = r_resp;
  assign read_data_valid_o      = r_data_valid;
  assign register_address_o     = r_reg_addr;
  assign register_read_enable_o = r_reg_rd_en;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_read.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_lite_read
//  Description : Self-checking bench for axi4_lite_read (DEPTH=4, DATA=32,
//                ADDR=4). It uses a behavioural register file that returns
//                32'hA5A5_0000 + index. Expected R beats are queued when a
//                request is driven and compared on each R handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_read;

  localparam int DEPTH     = 4;
  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 4;

  logic                     clk_i;
  logic                     rst_clk_ni;
  logic [ADDR_SIZE-1:0]     read_address_i;
  logic                     read_address_valid_i;
  logic                     read_address_ready_o;
  logic [DATA_SIZE-1:0]     read_data_o;
  logic [1:0]               read_response_o;
  logic                     read_data_valid_o;
  logic                     read_data_ready_i;
  logic [$clog2(DEPTH)-1:0] register_address_o;
  logic                     register_read_enable_o;
  logic [DATA_SIZE-1:0]     register_data_i;

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;

  // expected beats: {resp, data}
  logic [DATA_SIZE+1:0] sb_q[$];

  axi4_lite_read #(
    .DEPTH     (DEPTH),
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) dut (
    .clk_i                  (clk_i),
    .rst_clk_ni             (rst_clk_ni),
    .read_address_i         (read_address_i),
    .read_address_valid_i   (read_address_valid_i),
    .read_address_ready_o   (read_address_ready_o),
    .read_data_o            (read_data_o),
    .read_response_o        (read_response_o),
    .read_data_valid_o      (read_data_valid_o),
    .read_data_ready_i      (read_data_ready_i),
    .register_address_o     (register_address_o),
    .register_read_enable_o (register_read_enable_o),
    .register_data_i        (register_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Register file: data is valid for exactly one cycle after the strobe.
  // Garbage is returned at all other times.
  always @(posedge clk_i) begin
    if (register_read_enable_o)
      register_data_i <= 32'hA5A5_0000 + 32'(register_address_o);
    else
      register_data_i <= 32'hDEAD_BEEF;
  end

  // R-channel monitor. It checks that data is stable under backpressure and
  // that each handshake matches the head of the scoreboard.
  logic                 hold_active = 1'b0;
  logic [DATA_SIZE+1:0] hold_val;
  always @(negedge clk_i) begin
    if (rst_clk_ni && read_data_valid_o) begin
      if (hold_active) begin
        tests++;
        if ({read_response_o, read_data_o} !== hold_val) begin
          fails++;
          $display("FAIL r_stable: got %h required %h", {read_response_o, read_data_o}, hold_val);
        end
      end
      if (read_data_ready_i) begin
        hold_active = 1'b0;
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL r_unexpected: got beat %h with nothing expected", {read_response_o, read_data_o});
        end else begin
          logic [DATA_SIZE+1:0] exp;
          exp = sb_q.pop_front();
          if ({read_response_o, read_data_o} !== exp) begin
            fails++;
            $display("FAIL r_beat: got resp/data %h required %h", {read_response_o, read_data_o}, exp);
          end
        end
      end else begin
        hold_active = 1'b1;
        hold_val    = {read_response_o, read_data_o};
      end
    end else begin
      hold_active = 1'b0;
    end
  end

  task automatic drive_tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk_i);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_clk_ni = 1'b0;
    read_address_i = '0; read_address_valid_i = 1'b0; read_data_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    tests++;
    if ({read_data_o, read_response_o, read_data_valid_o, register_address_o,
         register_read_enable_o, read_address_ready_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: data=%h resp=%b rvalid=%b ridx=%h ren=%b arready=%b required all 0",
               read_data_o, read_response_o, read_data_valid_o, register_address_o,
               register_read_enable_o, read_address_ready_o);
    end
    drive_tick();
    rst_clk_ni = 1'b1;
    @(negedge clk_i);
    tests++;
    if (read_address_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b required 1", read_address_ready_o);
    end
  endtask

  task automatic test_single();
    drive_tick();
    read_address_i = 4'd2; read_address_valid_i = 1'b1; read_data_ready_i = 1'b1;
    sb_q.push_back({2'b00, 32'hA5A5_0002});
    @(negedge clk_i);                       // cycle 0
    tests++;
    if (read_address_ready_o !== 1'b1) begin
      fails++; $display("FAIL single_arready: got %b required 1", read_address_ready_o);
    end
    drive_tick();
    read_address_valid_i = 1'b0;
    @(negedge clk_i);                       // cycle 1
    tests++;
    if (register_read_enable_o !== 1'b1 || register_address_o !== 2'd2 || read_address_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL single_strobe: ren=%b idx=%0d arready=%b required 1/2/0",
               register_read_enable_o, register_address_o, read_address_ready_o);
    end
    @(negedge clk_i);                       // cycle 2
    tests++;
    if (register_read_enable_o !== 1'b0 || read_data_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL single_cycle2: ren=%b rvalid=%b required 0/0", register_read_enable_o, read_data_valid_o);
    end
    @(negedge clk_i);                       // cycle 3
    tests++;
    if (read_data_valid_o !== 1'b1) begin
      fails++; $display("FAIL single_rvalid_n3: got %b required 1", read_data_valid_o);
    end
    @(negedge clk_i);                       // cycle 4
    tests++;
    if (read_data_valid_o !== 1'b0 || read_address_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL single_done: rvalid=%b arready=%b required 0/1", read_data_valid_o, read_address_ready_o);
    end
    wait_drain("single");
  endtask

  task automatic test_backpressure();
    drive_tick();
    read_address_i = 4'd1; read_address_valid_i = 1'b1; read_data_ready_i = 1'b0;
    sb_q.push_back({2'b00, 32'hA5A5_0001});
    drive_tick();
    read_address_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);            // cycle 3 after the next edge
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      tests++;
      if (read_data_valid_o !== 1'b1 || read_data_o !== 32'hA5A5_0001) begin
        fails++;
        $display("FAIL bp_hold[%0d]: rvalid=%b data=%h required 1/a5a50001", i, read_data_valid_o, read_data_o);
      end
    end
    drive_tick();
    read_data_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    tests++;
    if (read_data_valid_o !== 1'b0 || read_address_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL bp_done: rvalid=%b arready=%b required 0/1", read_data_valid_o, read_address_ready_o);
    end
    wait_drain("bp");
  endtask

  task automatic test_back_to_back();
    int first_hs = -1;
    int second_hs = -1;
    drive_tick();
    read_address_i = 4'd0; read_address_valid_i = 1'b1; read_data_ready_i = 1'b1;
    sb_q.push_back({2'b00, 32'hA5A5_0000});
    sb_q.push_back({2'b00, 32'hA5A5_0003});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (read_address_valid_i && read_address_ready_o) begin
        if (first_hs < 0) first_hs = cyc;
        else if (second_hs < 0) second_hs = cyc;
      end
      if (second_hs >= 0) break;
      drive_tick();
      if (first_hs >= 0) read_address_i = 4'd3;
    end
    drive_tick();
    read_address_valid_i = 1'b0;
    tests++;
    if (first_hs < 0 || second_hs < 0 || (second_hs - first_hs) != 4) begin
      fails++;
      $display("FAIL b2b_spacing: got first=%0d second=%0d required spacing 4", first_hs, second_hs);
    end
    wait_drain("b2b");
  endtask

  task automatic test_out_of_range();
    logic       exp_ren;
    logic [1:0] exp_idx;
`ifdef AXI4_LITE_READ_ADDR_CHECK_EN
    exp_ren = 1'b0; exp_idx = 2'd1;
    sb_q.push_back({2'b10, 32'h0000_0000});
`else
    exp_ren = 1'b1; exp_idx = 2'd1;
    sb_q.push_back({2'b00, 32'hA5A5_0001});
`endif
    drive_tick();
    read_address_i = 4'd9; read_address_valid_i = 1'b1; read_data_ready_i = 1'b1;
    drive_tick();
    read_address_valid_i = 1'b0;
    @(negedge clk_i);                       // cycle 1
    tests++;
    if (register_read_enable_o !== exp_ren || (exp_ren && register_address_o !== exp_idx)) begin
      fails++;
      $display("FAIL oor_strobe: ren=%b idx=%0d required ren=%b idx=%0d",
               register_read_enable_o, register_address_o, exp_ren, exp_idx);
    end
    repeat (2) @(negedge clk_i);            // cycle 3
    tests++;
    if (read_data_valid_o !== 1'b1) begin
      fails++; $display("FAIL oor_rvalid_n3: got %b required 1", read_data_valid_o);
    end
    wait_drain("oor");
  endtask

  task automatic test_reset_midop();
    drive_tick();
    read_address_i = 4'd2; read_address_valid_i = 1'b1; read_data_ready_i = 1'b1;
    drive_tick();                           // FETCH
    read_address_valid_i = 1'b0;
    drive_tick();                           // CAPTURE
    rst_clk_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    tests++;
    if ({read_data_o, read_response_o, read_data_valid_o, register_address_o,
         register_read_enable_o, read_address_ready_o} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: data=%h resp=%b rvalid=%b idx=%h ren=%b arready=%b required all 0",
               read_data_o, read_response_o, read_data_valid_o, register_address_o,
               register_read_enable_o, read_address_ready_o);
    end
    drive_tick();
    rst_clk_ni = 1'b1;
    @(negedge clk_i);
    tests++;
    if (read_address_ready_o !== 1'b1) begin
      fails++; $display("FAIL midreset_ready: got %b required 1", read_address_ready_o);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      tests++;
      if (read_data_valid_o !== 1'b0) begin
        fails++; $display("FAIL midreset_no_rvalid[%0d]: got %b required 0", i, read_data_valid_o);
      end
    end
    drive_tick();
    read_address_i = 4'd3; read_address_valid_i = 1'b1;
    sb_q.push_back({2'b00, 32'hA5A5_0003});
    drive_tick();
    read_address_valid_i = 1'b0;
    wait_drain("midreset_new");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_reset_midop();
    repeat (3) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/axi4_lite_read.md
AXI4_LITE_READ -- requirements
Module: axi4_lite_read

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of registers in the attached register file.
REQ-002 The block SHALL have parameter DATA_SIZE, default 32: register and read-data width in bits.
REQ-003 The block SHALL have parameter ADDR_SIZE, default 4: read-address width in bits, with ADDR_SIZE >= $clog2(DEPTH); addresses are register indices.
REQ-004 The block SHALL have ports:
- clk_i  in  1  the single clock.
- rst_clk_ni  in  1  reset, synchronous and active-low.
- read_address_i  in  ADDR_SIZE  AR address.
- read_address_valid_i  in  1  AR valid.
- read_address_ready_o  out  1  AR ready.
- read_data_o  out  DATA_SIZE  R data.
- read_response_o  out  2  R response.
- read_data_valid_o  out  1  R valid.
- read_data_ready_i  in  1  R ready.
- register_address_o  out  $clog2(DEPTH)  register-file read index.
- register_read_enable_o  out  1  one-cycle register-file read strobe.
- register_data_i  in  DATA_SIZE  register-file data, valid exactly one cycle after the strobe.

Function
REQ-005 The FSM SHALL have four states, IDLE -> FETCH -> CAPTURE -> RESP -> IDLE, and SHALL advance only on the conditions below.
REQ-006 read_address_ready_o SHALL be 1 in IDLE only, decoded from the state register; an AR handshake is valid&ready in IDLE.
REQ-007 On an AR handshake in cycle N, the block SHALL latch read_address_i and move to FETCH.
REQ-008 In FETCH (cycle N+1), the block SHALL assert register_read_enable_o for exactly one cycle, with register_address_o = the latched address low $clog2(DEPTH) bits, and then move to CAPTURE.
REQ-009 In CAPTURE (cycle N+2), the block SHALL register register_data_i into read_data_o, set read_response_o, and move to RESP.
REQ-010 read_data_valid_o SHALL first be 1 in cycle N+3 and SHALL stay 1 in RESP until read_data_ready_i=1.
REQ-011 read_data_o and read_response_o SHALL stay constant while read_data_valid_o=1 and read_data_ready_i=0.
REQ-012 On the R handshake, the block SHALL deassert read_data_valid_o in the next cycle and return to IDLE; minimum spacing between AR handshakes is 4 cycles, with no overlap or queuing.
REQ-013 read_address_valid_i asserted outside IDLE SHALL be ignored; the request is accepted on return to IDLE if it is still held.
REQ-014 read_data_ready_i asserted before read_data_valid_o SHALL have no effect.
REQ-015 register_read_enable_o SHALL be 0 in every state except FETCH.
REQ-016 For an in-range read, read_response_o SHALL be 2'b00 (OKAY).

Reset
REQ-017 While rst_clk_ni=0 at a rising edge, the state SHALL become IDLE and every output register SHALL become 0: read_data_o, read_response_o, read_data_valid_o, register_address_o, register_read_enable_o.
REQ-018 read_address_ready_o SHALL be 0 during reset and 1 from the first cycle after rst_clk_ni returns to 1.
REQ-019 Reset asserted in any state SHALL abort the transaction with no response issued, and any pending R beat SHALL be discarded.

Configuration
REQ-020 The block SHALL provide the macro AXI4_LITE_READ_ADDR_CHECK_EN, which enables out-of-range address checking.
REQ-021 With AXI4_LITE_READ_ADDR_CHECK_EN defined, a latched address >= DEPTH SHALL:
- suppress the FETCH strobe (register_read_enable_o stays 0);
- return read_data_o=0 and read_response_o=2'b10 (SLVERR);
- keep the same N+3 timing.
REQ-022 With AXI4_LITE_READ_ADDR_CHECK_EN undefined, every address SHALL be truncated to $clog2(DEPTH) bits and SHALL return OKAY.

Verification (DEPTH=4, DATA_SIZE=32, ADDR_SIZE=4; register file returns 32'hA5A5_0000+index)
REQ-023 Single read: AR addr 2 at cycle 0, rready=1 -> strobe at cycle 1 with register_address_o=2; rvalid at cycle 3 with data 32'hA5A5_0002 and resp 2'b00; rvalid=0 at cycle 4.
REQ-024 Backpressure: addr 1 with rready=0 for 5 cycles -> rvalid held with data 32'hA5A5_0001 stable throughout; rready=1 completes; ready_o=1 on the next cycle.
REQ-025 Back-to-back: arvalid held high for addrs 0 then 3 -> second AR accepted 4 cycles after the first; responses 32'hA5A5_0000 then 32'hA5A5_0003, in order.
REQ-026 Out of range: addr 4'd9 with macro defined -> no strobe, data 0, resp 2'b10 at cycle 3; without the macro -> strobe with register_address_o=1, data 32'hA5A5_0001, resp 2'b00.
REQ-027 Reset mid-op: rst_clk_ni=0 in CAPTURE -> all outputs 0 next cycle, no rvalid ever issued; after release, ready_o=1 and a new read to addr 3 completes normally.
